// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART: TX FIFO, STATUS/DIV registers; UART_RX_EN adds a receiver with an RX holding register.
// First start bit leaves txd one edge after the FIFO push; writes to a full FIFO are dropped and flagged in tx_ovf.
module mmio_uart #(
  parameter int          FIFO_DEPTH  = 8,
  parameter int          FIFO_AW     = 3,
  parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        w_en,
  input  logic        rd_en,
  input  logic [2:0]  addr,
  input  logic [15:0] data_w,
  output logic [15:0] data_r,
  output logic        txd,
  input  logic        rxd,
  output logic        irq
);

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

  logic wr_acc, data_wr, status_wr, div_wr;
  assign wr_acc    = sel & w_en;
  assign data_wr   = wr_acc && (addr[2:1] == REG_DATA);
  assign status_wr = wr_acc && (addr[2:1] == REG_STATUS);
  assign div_wr    = wr_acc && (addr[2:1] == REG_DIV);

  logic unused_addr0;
  assign unused_addr0 = addr[0];

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               tx_full, tx_empty, push, pop;
  logic [15:0]        div_q, div_d;
  logic               tx_ovf_q, tx_ovf_d;
  uart_state_e        tx_state_q, tx_state_d;
  logic [7:0]         tx_shift_q, tx_shift_d;
  logic [2:0]         tx_idx_q, tx_idx_d;
  logic [15:0]        tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic               txd_q, txd_d;
  logic               rx_valid, rx_overrun, rx_frame_err;
  logic [7:0]         rx_byte;
  logic [15:0]        status;

  assign tx_full  = (count_q == (FIFO_AW+1)'(FIFO_DEPTH));
  assign tx_empty = (count_q == '0);
  // Full is judged on the registered count, so a same-cycle pop never rescues a push.
  assign push     = data_wr & ~tx_full;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = data_w[7:0];
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    div_d    = div_q;
    tx_ovf_d = tx_ovf_q;
    if (div_wr) div_d = (data_w == 16'd0) ? 16'd1 : data_w;
    if (status_wr && data_w[3]) tx_ovf_d = 1'b0;
    if (data_wr && tx_full) tx_ovf_d = 1'b1;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_idx_d   = tx_idx_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    pop        = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        if (!tx_empty) begin
          pop        = 1'b1;
          tx_shift_d = mem_q[rd_ptr_q];
          tx_div_d   = div_q;
          tx_cnt_d   = div_q - 16'd1;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d   = tx_div_q - 16'd1;
          tx_idx_d   = 3'd0;
          tx_state_d = ST_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d   = tx_div_q - 16'd1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_idx_d   = tx_idx_q + 3'd1;
          if (tx_idx_q == 3'd7) tx_state_d = ST_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == 16'd0) begin
          if (!tx_empty) begin
            pop        = 1'b1;
            tx_shift_d = mem_q[rd_ptr_q];
            tx_div_d   = div_q;
            tx_cnt_d   = div_q - 16'd1;
            tx_state_d = ST_START;
          end else begin
            tx_state_d = ST_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
    // Registered line level follows the next state so txd never glitches.
    txd_d = (tx_state_d == ST_START) ? 1'b0 :
            (tx_state_d == ST_DATA)  ? tx_shift_d[0] : 1'b1;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      div_q      <= DEFAULT_DIV;
      tx_ovf_q   <= 1'b0;
      tx_state_q <= ST_IDLE;
      tx_shift_q <= '0;
      tx_idx_q   <= '0;
      tx_cnt_q   <= '0;
      tx_div_q   <= DEFAULT_DIV;
      txd_q      <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      div_q      <= div_d;
      tx_ovf_q   <= tx_ovf_d;
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_idx_q   <= tx_idx_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      txd_q      <= txd_d;
    end
  end

`ifdef UART_RX_EN
  logic        data_rd;
  logic        rxd_s1_q, rxd_s2_q, rxd_prev_q;
  uart_state_e rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d;
  logic        rx_frame_err_q, rx_frame_err_d, rx_done, rx_bad;

  assign data_rd = sel && rd_en && (addr[2:1] == REG_DATA);
  assign rx_half = (div_q[15:1] == 15'd0) ? 16'd1 : {1'b0, div_q[15:1]};

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    rx_bad     = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (rxd_prev_q && !rxd_s2_q) begin
          rx_div_d   = div_q;
          rx_cnt_d   = rx_half - 16'd1;
          rx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (rx_cnt_q == 16'd0) begin
          if (rxd_s2_q) begin
            rx_state_d = ST_IDLE;
          end else begin
            rx_cnt_d   = rx_div_q - 16'd1;
            rx_idx_d   = 3'd0;
            rx_state_d = ST_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = rx_div_q - 16'd1;
          rx_idx_d   = rx_idx_q + 3'd1;
          if (rx_idx_q == 3'd7) rx_state_d = ST_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (rx_cnt_q == 16'd0) begin
          rx_state_d = ST_IDLE;
          rx_bad     = ~rxd_s2_q;
          rx_done    = rxd_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
    rx_byte_d      = rx_done ? rx_shift_q : rx_byte_q;
    rx_valid_d     = rx_done | (rx_valid_q & ~data_rd);
    // A byte landing in the same cycle as the draining read is not an overrun.
    rx_overrun_d   = (rx_overrun_q & ~(status_wr & data_w[5])) | (rx_done & rx_valid_q & ~data_rd);
    rx_frame_err_d = (rx_frame_err_q & ~(status_wr & data_w[6])) | rx_bad;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_s1_q       <= 1'b1;
      rxd_s2_q       <= 1'b1;
      rxd_prev_q     <= 1'b1;
      rx_state_q     <= ST_IDLE;
      rx_cnt_q       <= '0;
      rx_div_q       <= DEFAULT_DIV;
      rx_idx_q       <= '0;
      rx_shift_q     <= '0;
      rx_byte_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_overrun_q   <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      rxd_s1_q       <= rxd;
      rxd_s2_q       <= rxd_s1_q;
      rxd_prev_q     <= rxd_s2_q;
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_div_q       <= rx_div_d;
      rx_idx_q       <= rx_idx_d;
      rx_shift_q     <= rx_shift_d;
      rx_byte_q      <= rx_byte_d;
      rx_valid_q     <= rx_valid_d;
      rx_overrun_q   <= rx_overrun_d;
      rx_frame_err_q <= rx_frame_err_d;
    end
  end

  assign rx_valid     = rx_valid_q;
  assign rx_overrun   = rx_overrun_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_byte      = rx_byte_q;
`else
  logic unused_rx;
  assign unused_rx    = rxd ^ rd_en;
  assign rx_valid     = 1'b0;
  assign rx_overrun   = 1'b0;
  assign rx_frame_err = 1'b0;
  assign rx_byte      = 8'h00;
`endif

  assign status = {8'(count_q), 1'b0, rx_frame_err, rx_overrun, rx_valid,
                   tx_ovf_q, (tx_state_q != ST_IDLE), tx_empty, tx_full};

  always_comb begin
    data_r = 16'h0000;
    case (addr[2:1])
      REG_DATA:   data_r = {8'h00, rx_byte};
      REG_STATUS: data_r = status;
      REG_DIV:    data_r = div_q;
      default:    data_r = 16'h0000;
    endcase
  end

  assign txd = txd_q;
  assign irq = tx_empty | rx_valid;

endmodule

// File: doc/mmio_uart.md
Name: mmio_uart

Overview:
- Memory-mapped UART peripheral in the I/O window, fed by the memory unit's bus decode.
- CPU writes bytes to a TX FIFO; the block serialises them as 8N1 frames on `txd`.
- STATUS and baud-divisor registers are exposed.
- Optional receiver adds an RX holding register.
- Read data is combinational; register writes and pops commit on the rising clock edge.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64
- FIFO_AW, 3, log2(FIFO_DEPTH)
- DEFAULT_DIV, 16'd104, clocks per bit after reset

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- sel  input  1  block selected by the upstream address decode
- w_en  input  1  bus write strobe; qualified by sel
- rd_en  input  1  bus read strobe; qualified by sel; used only for pop side effects
- addr  input  3  byte offset [2:0]; bit 0 ignored; registers: 0 DATA, 2 STATUS, 4 DIV, 6 reserved
- data_w  input  16  write data
- data_r  output  16  read data, combinational from addr
- txd  output  1  serial out, idle high
- rxd  input  1  serial in; used only with UART_RX_EN
- irq  output  1  high when `tx_empty`, or `rx_valid` with UART_RX_EN

Behaviour:
- Reset: all of the following take effect at the rising edge where rst_n=0, regardless of frame in progress.
  - FIFO emptied; FSM to IDLE; `txd`=1.
  - DIV=DEFAULT_DIV.
  - Sticky bits cleared; `rx_valid`=0.
  - `irq`=1, because the TX FIFO is empty.
- DATA write (sel&w_en, addr=0):
  - Push data_w[7:0] if FIFO not full.
  - If full, drop the byte and set `tx_ovf`.
  - A push while full is rejected even if the FSM pops in the same cycle.
- DATA read: returns {8'h00, rx_byte} with UART_RX_EN, else 16'h0000.
- STATUS read:
  - [0] tx_full
  - [1] tx_empty
  - [2] tx_busy (FSM not IDLE)
  - [3] tx_ovf
  - [4] rx_valid
  - [5] rx_overrun
  - [6] rx_frame_err
  - [7] 0
  - [15:8] FIFO count
- STATUS write: bits 3/5/6 are write-1-to-clear; other bits ignored.
- DIV: reads the 16-bit divisor. Writing 0 stores 1. Writes at offset 6 are ignored; reads return 0.
- FIFO: circular, FIFO_AW-bit pointers plus count. Pointers wrap modulo FIFO_DEPTH.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty at an edge, pop the byte, latch DIV into the frame divisor, go to START. `txd` goes low after that edge.
  - Mid-frame DIV writes affect only the next frame.
  - Each bit lasts exactly the frame divisor in clocks; a down-counter reloads at divisor-1.
  - START (`txd`=0) -> DATA.
  - DATA sends bits 0..7, LSB first; a 3-bit index wraps 7 -> STOP.
  - STOP (`txd`=1) for one bit -> IDLE, or straight to START with a pop if the FIFO is non-empty (back-to-back frames, no idle gap).
- Latency: a byte written to an empty FIFO with the FSM in IDLE at edge N produces the `txd` falling edge after edge N+1.
- A push and a pop in the same cycle on a non-full FIFO leave the count unchanged.

Optional Feature:
- UART_RX_EN defined:
  - `rxd` passes through a 2-flop synchroniser.
  - RX FSM states: IDLE, START, DATA, STOP.
  - A falling edge starts a frame using the current DIV. START is verified at DIV/2 (integer division, minimum 1). If the line is high there, return to IDLE.
  - Data bits are then sampled every DIV clocks, LSB first.
  - Stop bit: if low, discard the byte and set `rx_frame_err`.
  - Otherwise store the byte in `rx_byte` and set `rx_valid`. If `rx_valid` was already 1, overwrite the byte and set `rx_overrun`.
  - A DATA read (sel&rd_en, addr=0) clears `rx_valid` at the edge. If a new byte completes in the same cycle, `rx_valid` stays 1 with the new byte and `rx_overrun` is not set.
- UART_RX_EN undefined:
  - `rxd` ignored; no RX logic.
  - STATUS[6:4]=0; DATA reads 0.
  - `irq` reflects `tx_empty` only.

Test Plan:
- Reset: hold rst_n=0 two cycles -> `txd`=1, STATUS=16'h0002, DIV reads 104, `irq`=1.
- Frame timing: DIV=4, write DATA=16'h00A5 -> `txd` low 4 clocks starting 2 edges after the write, then bits 1,0,1,0,0,1,0,1 for 4 clocks each, stop high 4 clocks; STATUS[2] returns to 0.
- Overflow: DIV=100, write 10 bytes back-to-back -> first pops to FSM, 8 fill the FIFO, 10th dropped. STATUS[0]=1, [3]=1, [15:8]=8. Write STATUS=16'h0008 -> bit 3 clears.
- Back-to-back and wrap: DIV=2, stream 20 bytes 0x00..0x13 while respecting tx_full -> bytes appear in order, no idle gap between stop and start, pointers wrap cleanly.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 -> next cycle `txd`=1, FIFO empty, DIV=104; a new write afterwards sends a clean frame.
- RX (UART_RX_EN): DIV=8, drive 8N1 0x3C on `rxd` -> STATUS[4]=1, DATA reads 16'h003C, read clears bit 4. Send two bytes without reading -> `rx_overrun`=1. Bad stop bit -> `rx_frame_err`=1 and `rx_valid` unchanged.
